// File: rtl/ans_encode_ctrl_if.sv
// Handshake and configuration bundle between a symbol source / encoder pair and ans_encode_ctrl.
// The master side drives configuration, symbols and encoder feedback; the slave side is the controller.
interface ans_encode_ctrl_if #(
  parameter int SYM_WIDTH   = 8,
  parameter int CNT_WIDTH   = 8,
  parameter int STATE_WIDTH = 16,
  parameter int IDX_WIDTH   = 4
);
  logic                           cfg_we;
  logic [IDX_WIDTH-1:0]           cfg_idx;
  logic [CNT_WIDTH-1:0]           cfg_count;
  logic                           cfg_commit;
  logic                           cfg_busy;
  logic                           frame_start;
  logic [IDX_WIDTH-1:0]           sym_idx;
  logic                           sym_vld;
  logic                           sym_rdy;
  logic [CNT_WIDTH-1:0]           enc_s_count;
  logic [SYM_WIDTH+CNT_WIDTH-1:0] enc_s_cum;
  logic [STATE_WIDTH-1:0]         enc_total;
  logic                           enc_in_vld;
  logic                           enc_in_rdy;
  logic                           enc_out_vld;
  logic                           enc_rst_n;
  logic                           err_zero;
  logic                           err_total;
  logic [15:0]                    sym_cnt;

  modport master (
    output cfg_we, cfg_idx, cfg_count, cfg_commit, frame_start, sym_idx, sym_vld,
           enc_in_rdy, enc_out_vld,
    input  cfg_busy, sym_rdy, enc_s_count, enc_s_cum, enc_total, enc_in_vld,
           enc_rst_n, err_zero, err_total, sym_cnt
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_count, cfg_commit, frame_start, sym_idx, sym_vld,
           enc_in_rdy, enc_out_vld,
    output cfg_busy, sym_rdy, enc_s_count, enc_s_cum, enc_total, enc_in_vld,
           enc_rst_n, err_zero, err_total, sym_cnt
  );
endinterface

// File: rtl/ans_encode_ctrl.sv
// Sequencer in front of an rANS encoder: frequency table, prefix-sum build, encoder reset,
// and a symbol handshake that re-presents a symbol whenever the encoder emits a byte instead.
module ans_encode_ctrl #(
  parameter int SYM_WIDTH   = 8,
  parameter int CNT_WIDTH   = 8,
  parameter int STATE_WIDTH = 16,
  parameter int NUM_SYMS    = 16,
  parameter int IDX_WIDTH   = 4
) (
  input logic              clk,
  input logic              rst,
  ans_encode_ctrl_if.slave bus
);
  localparam int CUM_W = SYM_WIDTH + CNT_WIDTH;

  typedef enum logic [2:0] {IDLE, BUILD, ERST, READY, ISSUE, WAIT, DRAIN} state_t;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_count [NUM_SYMS];
  logic [CUM_W-1:0]       r_cum   [NUM_SYMS];
  logic [IDX_WIDTH-1:0]   r_bidx;
  logic [STATE_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]   r_s_count;
  logic [CUM_W-1:0]       r_s_cum;
  logic [STATE_WIDTH-1:0] r_total;
  logic                   r_in_vld;
  logic                   r_rst_n;
  logic                   r_busy;
  logic                   r_sym_rdy;
  logic                   r_err_zero;
  logic                   r_err_total;
  logic [15:0]            r_sym_cnt;

  logic [STATE_WIDTH:0]   w_sum;
  logic [CNT_WIDTH-1:0]   w_sel_count;
  logic                   w_tbl_wr;
  logic                   w_last;

  // Extra top bit of the accumulator sum is the overflow carry.
  assign w_sum       = {1'b0, r_acc} + (STATE_WIDTH+1)'(r_count[r_bidx]);
  assign w_sel_count = r_count[bus.sym_idx];
  assign w_tbl_wr    = bus.cfg_we && ((r_state == IDLE) || (r_state == READY));
  assign w_last      = (r_bidx == IDX_WIDTH'(NUM_SYMS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_SYMS; k++) r_count[k] <= '0;
    end else if (w_tbl_wr) begin
      r_count[bus.cfg_idx] <= bus.cfg_count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bidx      <= '0;
      r_acc       <= '0;
      for (int k = 0; k < NUM_SYMS; k++) r_cum[k] <= '0;
      r_s_count   <= '0;
      r_s_cum     <= '0;
      r_total     <= '0;
      r_in_vld    <= 1'b0;
      r_rst_n     <= 1'b0;
      r_busy      <= 1'b0;
      r_sym_rdy   <= 1'b0;
      r_err_zero  <= 1'b0;
      r_err_total <= 1'b0;
      r_sym_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cfg_commit) begin
            r_state <= BUILD;
            r_busy  <= 1'b1;
            r_rst_n <= 1'b1;
            r_bidx  <= '0;
            r_acc   <= '0;
          end
        end
        BUILD: begin
          r_cum[r_bidx] <= CUM_W'(r_acc);
          r_acc         <= w_sum[STATE_WIDTH-1:0];
          if (w_sum[STATE_WIDTH]) r_err_total <= 1'b1;
          if (w_last) begin
            r_total <= w_sum[STATE_WIDTH-1:0];
            r_state <= ERST;
            r_rst_n <= 1'b0;
          end else begin
            r_bidx <= r_bidx + IDX_WIDTH'(1);
          end
        end
        ERST: begin
          r_state   <= READY;
          r_rst_n   <= 1'b1;
          r_busy    <= 1'b0;
          r_sym_rdy <= 1'b1;
          r_sym_cnt <= '0;
        end
        READY: begin
          if (bus.cfg_commit) begin
            r_state   <= BUILD;
            r_busy    <= 1'b1;
            r_sym_rdy <= 1'b0;
            r_bidx    <= '0;
            r_acc     <= '0;
          end else if (bus.frame_start) begin
            r_state   <= ERST;
            r_busy    <= 1'b1;
            r_sym_rdy <= 1'b0;
            r_rst_n   <= 1'b0;
          end else if (bus.sym_vld) begin
            // A zero-frequency symbol cannot be encoded; swallow it and flag it.
            if (w_sel_count == '0) begin
              r_err_zero <= 1'b1;
            end else begin
              r_s_count <= w_sel_count;
              r_s_cum   <= r_cum[bus.sym_idx];
              r_in_vld  <= 1'b1;
              r_sym_rdy <= 1'b0;
              r_state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.enc_in_rdy) begin
            r_in_vld <= 1'b0;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          // An output byte here means the encoder renormalised rather than absorbed.
          if (bus.enc_out_vld) begin
            r_state <= DRAIN;
          end else begin
            r_sym_cnt <= r_sym_cnt + 16'd1;
            r_sym_rdy <= 1'b1;
            r_state   <= READY;
          end
        end
        DRAIN: begin
          if (bus.enc_in_rdy) begin
            r_in_vld <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_busy    = r_busy;
  assign bus.sym_rdy     = r_sym_rdy;
  assign bus.enc_s_count = r_s_count;
  assign bus.enc_s_cum   = r_s_cum;
  assign bus.enc_total   = r_total;
  assign bus.enc_in_vld  = r_in_vld;
  assign bus.enc_rst_n   = r_rst_n;
  assign bus.err_zero    = r_err_zero;
  assign bus.err_total   = r_err_total;
  assign bus.sym_cnt     = r_sym_cnt;
endmodule

// File: tb/tb_ans_encode_ctrl.sv
// Bench for ans_encode_ctrl: a behavioural rANS encoder on the far side of the handshake,
// and a reference model that encodes the accepted symbol stream directly from the frequency table.
module tb_ans_encode_ctrl;
  localparam int SYM_WIDTH   = 8;
  localparam int CNT_WIDTH   = 8;
  localparam int STATE_WIDTH = 16;
  localparam int NUM_SYMS    = 16;
  localparam int IDX_WIDTH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ans_encode_ctrl_if #(.SYM_WIDTH(SYM_WIDTH), .CNT_WIDTH(CNT_WIDTH),
                       .STATE_WIDTH(STATE_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

  ans_encode_ctrl #(.SYM_WIDTH(SYM_WIDTH), .CNT_WIDTH(CNT_WIDTH), .STATE_WIDTH(STATE_WIDTH),
                    .NUM_SYMS(NUM_SYMS), .IDX_WIDTH(IDX_WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Encoder model: byte-wise rANS, state reset to 5, emits one byte per attempt while x >= f<<8.
  longint     e_x        = 5;
  logic       e_in_rdy   = 1'b1;
  logic       e_out_vld  = 1'b0;
  logic       tb_out_rdy = 1'b1;
  logic       tb_block   = 1'b0;
  logic       rand_stall = 1'b0;
  logic       stall_bit  = 1'b0;
  logic       prev_hs    = 1'b0;
  int         vld_cycles = 0;
  int         viol       = 0;
  longint     ef, ec, em;
  logic [7:0] byte_q[$];
  int         abs_cnt_q[$];
  int         abs_cum_q[$];

  assign bus.enc_in_rdy  = e_in_rdy && !tb_block;
  assign bus.enc_out_vld = e_out_vld;

  always @(negedge clk) stall_bit <= ($urandom_range(0, 3) == 0);

  always @(posedge clk) begin
    if (bus.enc_in_vld === 1'b1) vld_cycles++;
    if (prev_hs && bus.enc_in_vld === 1'b1) viol++;
    prev_hs = (bus.enc_in_vld === 1'b1) && (bus.enc_in_rdy === 1'b1);
    if (bus.enc_rst_n !== 1'b1) begin
      e_x = 5;
      e_in_rdy  <= 1'b1;
      e_out_vld <= 1'b0;
    end else if (e_out_vld) begin
      if (tb_out_rdy && !(rand_stall && stall_bit)) begin
        e_out_vld <= 1'b0;
        e_in_rdy  <= 1'b1;
      end
    end else if (bus.enc_in_vld === 1'b1 && bus.enc_in_rdy === 1'b1) begin
      ef = longint'(bus.enc_s_count);
      ec = longint'(bus.enc_s_cum);
      em = longint'(bus.enc_total);
      if (ef == 0) begin
        viol++;
      end else if (e_x >= (ef << 8)) begin
        byte_q.push_back(e_x[7:0]);
        e_x = e_x >> 8;
        e_out_vld <= 1'b1;
        e_in_rdy  <= 1'b0;
      end else begin
        e_x = (e_x / ef) * em + ec + (e_x % ef);
        abs_cnt_q.push_back(int'(ef));
        abs_cum_q.push_back(int'(ec));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_count = '0; bus.cfg_commit = 1'b0;
    bus.frame_start = 1'b0; bus.sym_idx = '0; bus.sym_vld = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input int val);
    bus.cfg_we = 1'b1; bus.cfg_idx = IDX_WIDTH'(idx); bus.cfg_count = CNT_WIDTH'(val);
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic commit_count(output int n);
    bus.cfg_commit = 1'b1;
    @(negedge clk);
    bus.cfg_commit = 1'b0;
    n = 0;
    while (bus.cfg_busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
  endtask

  task automatic wait_rdy();
    int t = 0;
    while (bus.sym_rdy !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    if (bus.sym_rdy !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_rdy: sym_rdy=%b after %0d cycles, required 1", bus.sym_rdy, t);
    end
  endtask

  task automatic send_sym(input int idx);
    wait_rdy();
    bus.sym_idx = IDX_WIDTH'(idx); bus.sym_vld = 1'b1;
    @(negedge clk);
    bus.sym_vld = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.sym_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_sym_rdy: got %b want 0", bus.sym_rdy); end
    n_cmp++; if (bus.enc_in_vld !== 1'b0) begin n_fail++; $display("FAIL rst_in_vld: got %b want 0", bus.enc_in_vld); end
    n_cmp++; if (bus.enc_rst_n !== 1'b0) begin n_fail++; $display("FAIL rst_enc_rst_n: got %b want 0", bus.enc_rst_n); end
    n_cmp++; if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.cfg_busy); end
    n_cmp++; if ({bus.err_zero, bus.err_total} !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b%b want 00", bus.err_zero, bus.err_total); end
    n_cmp++; if (bus.sym_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_sym_cnt: got %0d want 0", bus.sym_cnt); end
    n_cmp++; if ({bus.enc_total, bus.enc_s_count, bus.enc_s_cum} !== '0) begin n_fail++; $display("FAIL rst_enc_data: total=%h cnt=%h cum=%h want 0", bus.enc_total, bus.enc_s_count, bus.enc_s_cum); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.enc_rst_n !== 1'b0) begin n_fail++; $display("FAIL idle_enc_rst_n: got %b want 0", bus.enc_rst_n); end
  endtask

  task automatic test_build();
    int n;
    cfg_write(0, 3);
    cfg_write(1, 1);
    commit_count(n);
    n_cmp++; if (n != 17) begin n_fail++; $display("FAIL build_busy_cycles: got %0d want 17", n); end
    n_cmp++; if (bus.enc_total !== 16'd4) begin n_fail++; $display("FAIL build_total: got %0d want 4", bus.enc_total); end
    n_cmp++; if (bus.sym_rdy !== 1'b1) begin n_fail++; $display("FAIL build_sym_rdy: got %b want 1", bus.sym_rdy); end
    n_cmp++; if (bus.enc_rst_n !== 1'b1) begin n_fail++; $display("FAIL build_enc_rst_n: got %b want 1", bus.enc_rst_n); end
    n_cmp++; if (bus.err_total !== 1'b0) begin n_fail++; $display("FAIL build_err_total: got %b want 0", bus.err_total); end
  endtask

  task automatic test_symbols();
    int exp_cnt[4] = '{3, 1, 1, 1};
    int exp_cum[4] = '{0, 3, 3, 3};
    int sq[4]      = '{0, 1, 1, 1};
    abs_cnt_q.delete(); abs_cum_q.delete(); byte_q.delete();
    foreach (sq[i]) send_sym(sq[i]);
    wait_rdy();
    n_cmp++; if (byte_q.size() != 0) begin n_fail++; $display("FAIL sym4_bytes: got %0d bytes want 0", byte_q.size()); end
    n_cmp++; if (e_x != 447) begin n_fail++; $display("FAIL sym4_state: got %0d want 447", e_x); end
    n_cmp++; if (bus.sym_cnt !== 16'd4) begin n_fail++; $display("FAIL sym4_cnt: got %0d want 4", bus.sym_cnt); end
    n_cmp++; if (abs_cnt_q.size() != 4) begin n_fail++; $display("FAIL sym4_abs_n: got %0d want 4", abs_cnt_q.size()); end
    for (int i = 0; i < 4 && i < abs_cnt_q.size(); i++) begin
      n_cmp++;
      if (abs_cnt_q[i] != exp_cnt[i] || abs_cum_q[i] != exp_cum[i]) begin
        n_fail++; $display("FAIL sym4_abs[%0d]: got cnt=%0d cum=%0d want cnt=%0d cum=%0d", i, abs_cnt_q[i], abs_cum_q[i], exp_cnt[i], exp_cum[i]);
      end
    end
    send_sym(1);
    wait_rdy();
    n_cmp++; if (byte_q.size() != 1 || byte_q[0] !== 8'hBF) begin n_fail++; $display("FAIL sym5_byte: got n=%0d first=%h want n=1 BF", byte_q.size(), (byte_q.size() > 0) ? byte_q[0] : 8'h00); end
    n_cmp++; if (e_x != 7) begin n_fail++; $display("FAIL sym5_state: got %0d want 7", e_x); end
    n_cmp++; if (bus.sym_cnt !== 16'd5) begin n_fail++; $display("FAIL sym5_cnt: got %0d want 5", bus.sym_cnt); end
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL sym5_double_issue: got %0d violations want 0", viol); end
  endtask

  task automatic test_drain_stall();
    int t = 0;
    int bad = 0;
    send_sym(1); send_sym(1); send_sym(1);
    wait_rdy();
    n_cmp++; if (e_x != 511) begin n_fail++; $display("FAIL drain_pre_state: got %0d want 511", e_x); end
    tb_out_rdy = 1'b0;
    send_sym(1);
    while (e_out_vld !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    n_cmp++; if (e_out_vld !== 1'b1) begin n_fail++; $display("FAIL drain_emit: out_vld=%b want 1", e_out_vld); end
    repeat (10) begin
      @(negedge clk);
      if (bus.enc_in_vld !== 1'b0 || bus.sym_rdy !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL drain_hold: got %0d cycles with in_vld/sym_rdy high want 0", bad); end
    tb_out_rdy = 1'b1;
    wait_rdy();
    n_cmp++; if (byte_q.size() != 2 || byte_q[byte_q.size()-1] !== 8'hFF) begin n_fail++; $display("FAIL drain_byte: got n=%0d want n=2 last FF", byte_q.size()); end
    n_cmp++; if (e_x != 7) begin n_fail++; $display("FAIL drain_state: got %0d want 7", e_x); end
    n_cmp++; if (bus.sym_cnt !== 16'd9) begin n_fail++; $display("FAIL drain_cnt: got %0d want 9", bus.sym_cnt); end
  endtask

  task automatic test_zero_count();
    int v0 = vld_cycles;
    n_cmp++; if (bus.err_zero !== 1'b0) begin n_fail++; $display("FAIL zero_pre_err: got %b want 0", bus.err_zero); end
    send_sym(5);
    n_cmp++; if (bus.sym_rdy !== 1'b1) begin n_fail++; $display("FAIL zero_rdy: got %b want 1", bus.sym_rdy); end
    n_cmp++; if (bus.err_zero !== 1'b1) begin n_fail++; $display("FAIL zero_err: got %b want 1", bus.err_zero); end
    repeat (3) @(negedge clk);
    n_cmp++; if (vld_cycles != v0) begin n_fail++; $display("FAIL zero_no_issue: got %0d in_vld cycles want %0d", vld_cycles, v0); end
    n_cmp++; if (bus.sym_cnt !== 16'd9) begin n_fail++; $display("FAIL zero_cnt: got %0d want 9", bus.sym_cnt); end
  endtask

  task automatic test_priority();
    int n = 0;
    int a0 = abs_cnt_q.size();
    bus.cfg_commit = 1'b1; bus.frame_start = 1'b1; bus.sym_idx = '0; bus.sym_vld = 1'b1;
    @(negedge clk);
    idle_inputs();
    bus.cfg_we = 1'b1; bus.cfg_idx = 4'd2; bus.cfg_count = 8'd9;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    n = 1;
    while (bus.cfg_busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    n_cmp++; if (n != 17) begin n_fail++; $display("FAIL prio_commit_busy: got %0d want 17", n); end
    n_cmp++; if (bus.enc_total !== 16'd4) begin n_fail++; $display("FAIL prio_we_in_build: total got %0d want 4", bus.enc_total); end
    n_cmp++; if (abs_cnt_q.size() != a0 || bus.sym_cnt !== 16'd0) begin n_fail++; $display("FAIL prio_commit_sym: abs %0d->%0d cnt=%0d want unchanged,0", a0, abs_cnt_q.size(), bus.sym_cnt); end
    send_sym(1);
    wait_rdy();
    n_cmp++; if (e_x != 23 || bus.sym_cnt !== 16'd1) begin n_fail++; $display("FAIL prio_pre_frame: state=%0d cnt=%0d want 23,1", e_x, bus.sym_cnt); end
    a0 = abs_cnt_q.size();
    bus.frame_start = 1'b1; bus.sym_idx = 4'd1; bus.sym_vld = 1'b1;
    @(negedge clk);
    idle_inputs();
    n = 0;
    while (bus.cfg_busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    n_cmp++; if (n != 1) begin n_fail++; $display("FAIL prio_frame_busy: got %0d want 1", n); end
    n_cmp++; if (bus.sym_cnt !== 16'd0 || abs_cnt_q.size() != a0) begin n_fail++; $display("FAIL prio_frame_sym: cnt=%0d abs=%0d want 0,%0d", bus.sym_cnt, abs_cnt_q.size(), a0); end
    send_sym(0);
    wait_rdy();
    n_cmp++; if (e_x != 6) begin n_fail++; $display("FAIL prio_frame_reset_state: got %0d want 6", e_x); end
  endtask

  task automatic test_random();
    int cnt[NUM_SYMS];
    int cum[NUM_SYMS];
    int tot, n, s;
    longint x;
    int exp_cnt_q[$];
    int exp_cum_q[$];
    logic [7:0] exp_b[$];
    rand_stall = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tot = 0;
      for (int i = 0; i < NUM_SYMS; i++) begin
        cnt[i] = $urandom_range(0, 7);
        cfg_write(i, cnt[i]);
      end
      for (int i = 0; i < NUM_SYMS; i++) begin cum[i] = tot; tot += cnt[i]; end
      commit_count(n);
      n_cmp++; if (n != 17) begin n_fail++; $display("FAIL rnd%0d_busy: got %0d want 17", r, n); end
      n_cmp++; if (bus.enc_total !== 16'(tot)) begin n_fail++; $display("FAIL rnd%0d_total: got %0d want %0d", r, bus.enc_total, tot); end
      abs_cnt_q.delete(); abs_cum_q.delete(); byte_q.delete();
      exp_cnt_q.delete(); exp_cum_q.delete(); exp_b.delete();
      x = 5;
      for (int k = 0; k < 30; k++) begin
        s = $urandom_range(0, NUM_SYMS - 1);
        send_sym(s);
        if (cnt[s] != 0) begin
          while (x >= (longint'(cnt[s]) << 8)) begin exp_b.push_back(x[7:0]); x = x >> 8; end
          x = (x / cnt[s]) * tot + cum[s] + (x % cnt[s]);
          exp_cnt_q.push_back(cnt[s]);
          exp_cum_q.push_back(cum[s]);
        end
      end
      wait_rdy();
      n_cmp++; if (bus.sym_cnt !== 16'(exp_cnt_q.size())) begin n_fail++; $display("FAIL rnd%0d_sym_cnt: got %0d want %0d", r, bus.sym_cnt, exp_cnt_q.size()); end
      n_cmp++; if (abs_cnt_q.size() != exp_cnt_q.size()) begin n_fail++; $display("FAIL rnd%0d_abs_n: got %0d want %0d", r, abs_cnt_q.size(), exp_cnt_q.size()); end
      for (int i = 0; i < exp_cnt_q.size() && i < abs_cnt_q.size(); i++) begin
        n_cmp++;
        if (abs_cnt_q[i] != exp_cnt_q[i] || abs_cum_q[i] != exp_cum_q[i]) begin
          n_fail++; $display("FAIL rnd%0d_abs[%0d]: got cnt=%0d cum=%0d want cnt=%0d cum=%0d", r, i, abs_cnt_q[i], abs_cum_q[i], exp_cnt_q[i], exp_cum_q[i]);
        end
      end
      n_cmp++; if (e_x != x) begin n_fail++; $display("FAIL rnd%0d_state: got %0d want %0d", r, e_x, x); end
      n_cmp++; if (byte_q != exp_b) begin n_fail++; $display("FAIL rnd%0d_bytes: got %0d bytes want %0d", r, byte_q.size(), exp_b.size()); end
      n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL rnd%0d_double_issue: got %0d want 0", r, viol); end
    end
    rand_stall = 1'b0;
  endtask

  task automatic test_full_table_and_rst();
    int n;
    for (int i = 0; i < NUM_SYMS; i++) cfg_write(i, 255);
    commit_count(n);
    n_cmp++; if (n != 17) begin n_fail++; $display("FAIL ff_busy: got %0d want 17", n); end
    n_cmp++; if (bus.enc_total !== 16'h0FF0) begin n_fail++; $display("FAIL ff_total: got %h want 0FF0", bus.enc_total); end
    n_cmp++; if (bus.err_total !== 1'b0) begin n_fail++; $display("FAIL ff_err_total: got %b want 0", bus.err_total); end
    tb_block = 1'b1;
    send_sym(0);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.enc_in_vld !== 1'b1) begin n_fail++; $display("FAIL issue_hold: in_vld=%b want 1", bus.enc_in_vld); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.enc_rst_n !== 1'b0 || bus.enc_in_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_enc: rst_n=%b in_vld=%b want 0,0", bus.enc_rst_n, bus.enc_in_vld); end
    n_cmp++; if (bus.sym_rdy !== 1'b0 || bus.cfg_busy !== 1'b0 || bus.err_zero !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: rdy=%b busy=%b err_zero=%b want 0,0,0", bus.sym_rdy, bus.cfg_busy, bus.err_zero); end
    n_cmp++; if (bus.enc_total !== 16'd0) begin n_fail++; $display("FAIL midrst_total: got %h want 0", bus.enc_total); end
    rst = 1'b0;
    tb_block = 1'b0;
    @(negedge clk);
    commit_count(n);
    n_cmp++; if (bus.enc_total !== 16'd0 || n != 17) begin n_fail++; $display("FAIL table_cleared: total=%h busy=%0d want 0,17", bus.enc_total, n); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_build();
    test_symbols();
    test_drain_stall();
    test_zero_count();
    test_priority();
    test_random();
    test_full_table_and_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
